// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI slave endpoint (CPOL=0) with tx buffer and rx word output; optional abort reporting via SPI_SLAVE_FRAME_ERR_EN
module spi_slave_responder #(
    parameter int REG_WIDTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_clk,
    input  logic                              cs_n,
    input  logic                              MOSI,
    output logic                              MISO,
    input  logic [REG_WIDTH-1:0]              tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic [REG_WIDTH-1:0]              rx_data,
    output logic                              rx_valid,
    output logic                              busy,
    output logic                              underrun
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic                              frame_err,
    output logic [$clog2(REG_WIDTH):0]        rx_bits
`endif
);

    localparam int CW = $clog2(REG_WIDTH) + 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(REG_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [REG_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [REG_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [REG_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d;
    logic [REG_WIDTH-1:0]   tx_buf_q, tx_buf_d;
    logic                   tx_full_q, tx_full_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall;
    logic consume, tx_load;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign tx_load   = tx_valid & ~tx_full_q;

    assign MISO     = tx_shift_q[REG_WIDTH-1];
    assign tx_ready = ~tx_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q == S_SHIFT);
    assign underrun = underrun_q;

    // Pin synchronizers plus the s_clk history bit used for edge detection
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], s_clk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sclk_hist_d = sclk_s;
    end

    // Frame FSM: next state, shift registers, rx capture and tx buffer handshake
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        consume    = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_shift_d = '0;
                bit_cnt_d  = '0;
                if (!cs_s) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (cs_s) begin
                    state_d    = S_IDLE;
                    tx_shift_d = '0;
                end else if (sclk_fall) begin
                    consume    = 1'b1;
                    tx_shift_d = tx_full_q ? tx_buf_q : '0;
                    underrun_d = ~tx_full_q;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    state_d    = S_DONE;
                end else if (cs_s) begin
                    state_d    = S_IDLE;
                    tx_shift_d = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[REG_WIDTH-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + CW'(1);
                end else if (sclk_fall) begin
                    tx_shift_d = {tx_shift_q[REG_WIDTH-2:0], 1'b0};
                end
            end
            S_DONE: begin
                bit_cnt_d = '0;
                state_d   = cs_s ? S_IDLE : S_ARM;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A consume in the same cycle as a load sees the old (empty) buffer; the new word waits
        if (consume) begin
            tx_full_d = 1'b0;
        end
        if (tx_load) begin
            tx_full_d = 1'b1;
            tx_buf_d  = tx_data;
        end
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_hist_q <= sclk_hist_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic          frame_err_q, frame_err_d;
    logic [CW-1:0] rx_bits_q, rx_bits_d;

    assign frame_err = frame_err_q;
    assign rx_bits   = rx_bits_q;

    // Abort detection mirrors the SHIFT branch priority: a completed frame is never an abort
    always_comb begin
        frame_err_d = (state_q == S_SHIFT) && cs_s && (bit_cnt_q != BIT_LAST);
        rx_bits_d   = frame_err_d ? bit_cnt_q : rx_bits_q;
    end

    // Abort report registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            rx_bits_q   <= '0;
        end else begin
            frame_err_q <= frame_err_d;
            rx_bits_q   <= rx_bits_d;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - directed self-checking bench for spi_slave_responder
module tb_spi_slave_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_clk = 1'b0;
    logic        cs_n = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [31:0] tx_data = 32'h0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        underrun;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic        frame_err;
    logic [5:0]  rx_bits;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int rxv_cnt = 0;
    int und_cnt = 0;
    int ferr_cnt = 0;

    spi_slave_responder #(.REG_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .s_clk(s_clk),
        .cs_n(cs_n),
        .MOSI(MOSI),
        .MISO(MISO),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .busy(busy),
        .underrun(underrun)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .frame_err(frame_err),
        .rx_bits(rx_bits)
`endif
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid) rxv_cnt++;
        if (underrun) und_cnt++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (frame_err) ferr_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (5) @(negedge clk);
    endtask

    task automatic load_tx(input logic [31:0] w);
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] mw);
        cs_n = 1'b0;
        half();
        s_clk = 1'b1;
        half();
        s_clk = 1'b0;
        MOSI  = mw[31];
        half();
    endtask

    task automatic frame(input logic [31:0] mw, output logic [31:0] got);
        got = 32'h0;
        for (int i = 31; i >= 0; i--) begin
            got[i] = MISO;
            s_clk = 1'b1;
            half();
            if (i > 0) begin
                s_clk = 1'b0;
                MOSI  = mw[i-1];
                half();
            end
        end
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        half();
        s_clk = 1'b0;
        MOSI  = 1'b0;
        half();
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] v5;
        int rxv0, und0, ferr0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_miso", {31'b0, MISO}, 32'h0);
        check("rst_tx_ready", {31'b0, tx_ready}, 32'h1);
        check("rst_rx_data", rx_data, 32'h0);
        check("rst_rx_valid", {31'b0, rx_valid}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_underrun", {31'b0, underrun}, 32'h0);
        rst = 1'b0;
        half();

        // Basic frame, including leading-edge rejection
        rxv0 = rxv_cnt; und0 = und_cnt;
        load_tx(32'hA5A5_0F0F);
        check("t1_tx_ready_full", {31'b0, tx_ready}, 32'h0);
        cs_n = 1'b0;
        half();
        s_clk = 1'b1;
        half();
        check("t6_lead_busy", {31'b0, busy}, 32'h0);
        check("t6_lead_miso", {31'b0, MISO}, 32'h0);
        s_clk = 1'b0;
        MOSI  = 1'b0;
        half();
        check("t1_busy", {31'b0, busy}, 32'h1);
        check("t1_miso_msb", {31'b0, MISO}, 32'h1);
        check("t1_tx_ready_empty", {31'b0, tx_ready}, 32'h1);
        frame(32'h1234_5678, got);
        check("t1_master_rx", got, 32'hA5A5_0F0F);
        check("t1_rx_data", rx_data, 32'h1234_5678);
        end_frame();
        check("t1_rxv_count", rxv_cnt - rxv0, 32'd1);
        check("t1_no_underrun", und_cnt - und0, 32'd0);
        check("t1_idle_busy", {31'b0, busy}, 32'h0);

        // Back-to-back frames with cs_n held low
        rxv0 = rxv_cnt; und0 = und_cnt;
        load_tx(32'hC3C3_3C3C);
        start_frame(32'hDEAD_BEEF);
        frame(32'hDEAD_BEEF, got);
        check("t2_f1_master_rx", got, 32'hC3C3_3C3C);
        check("t2_f1_rx_data", rx_data, 32'hDEAD_BEEF);
        s_clk = 1'b0;
        MOSI  = 1'b0;
        half();
        check("t2_f2_busy", {31'b0, busy}, 32'h1);
        frame(32'h0F1E_2D3C, got);
        check("t2_f2_master_rx", got, 32'h0);
        check("t2_f2_rx_data", rx_data, 32'h0F1E_2D3C);
        end_frame();
        check("t2_underrun_count", und_cnt - und0, 32'd1);
        check("t2_rxv_count", rxv_cnt - rxv0, 32'd2);

        // Mid-frame abort after 10 rising edges
        rxv0 = rxv_cnt; ferr0 = ferr_cnt;
        start_frame(32'hAAAA_AAAA);
        for (int i = 0; i < 10; i++) begin
            s_clk = 1'b1;
            half();
            s_clk = 1'b0;
            MOSI  = ~MOSI;
            half();
        end
        cs_n = 1'b1;
        half();
        check("t3_busy", {31'b0, busy}, 32'h0);
        check("t3_miso", {31'b0, MISO}, 32'h0);
        check("t3_rx_data_kept", rx_data, 32'h0F1E_2D3C);
        check("t3_no_rxv", rxv_cnt - rxv0, 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("t3_frame_err", ferr_cnt - ferr0, 32'd1);
        check("t3_rx_bits", {26'b0, rx_bits}, 32'd10);
`else
        check("t3_no_frame_err", ferr_cnt - ferr0, 32'd0);
`endif
        MOSI = 1'b0;
        half();

        // tx_valid held while the buffer is full
        und0 = und_cnt;
        @(negedge clk);
        tx_data  = 32'h9111_2222;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data  = 32'h3333_4444;
        repeat (3) @(negedge clk);
        check("t4_tx_ready_full", {31'b0, tx_ready}, 32'h0);
        start_frame(32'h0);
        check("t4_reloaded", {31'b0, tx_ready}, 32'h0);
        check("t4_miso_msb", {31'b0, MISO}, 32'h1);
        tx_valid = 1'b0;
        frame(32'h0, got);
        check("t4_first_word", got, 32'h9111_2222);
        end_frame();
        start_frame(32'h0F0F_F0F0);
        frame(32'h0F0F_F0F0, got);
        check("t4_second_word", got, 32'h3333_4444);
        check("t4_rx_data", rx_data, 32'h0F0F_F0F0);
        end_frame();
        check("t4_no_underrun", und_cnt - und0, 32'd0);

        // Asynchronous reset at bit 16, then a fresh frame
        v5 = 32'hCAFE_F00D;
        load_tx(32'h5A5A_5A5A);
        start_frame(v5);
        for (int i = 31; i > 15; i--) begin
            s_clk = 1'b1;
            half();
            s_clk = 1'b0;
            MOSI  = v5[i-1];
            half();
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_miso", {31'b0, MISO}, 32'h0);
        check("t5_rst_tx_ready", {31'b0, tx_ready}, 32'h1);
        check("t5_rst_rx_data", rx_data, 32'h0);
        check("t5_rst_busy", {31'b0, busy}, 32'h0);
        check("t5_rst_rx_valid", {31'b0, rx_valid}, 32'h0);
        check("t5_rst_underrun", {31'b0, underrun}, 32'h0);
        @(negedge clk);
        rst  = 1'b0;
        cs_n = 1'b1;
        MOSI = 1'b0;
        half();
        rxv0 = rxv_cnt;
        load_tx(32'h8001_7FFE);
        start_frame(32'hFFFF_FFFF);
        frame(32'hFFFF_FFFF, got);
        check("t5_master_rx", got, 32'h8001_7FFE);
        check("t5_rx_data", rx_data, 32'hFFFF_FFFF);
        end_frame();
        check("t5_rxv_count", rxv_cnt - rxv0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
